// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants and interrupt FSM state type for the IO port controller
package io_port_pkg;
  localparam int IO_DATA_W  = 8;
  localparam int IO_DEPTH   = 4;
  localparam int IO_INT_LEN = 2;
  typedef enum logic [1:0] {IDLE, PULSE, WAIT_EMPTY} int_state_t;
endpackage

// File: rtl/io_fifo.sv
// io_fifo: show-ahead circular FIFO with registered count and full/empty flags
module io_fifo import io_port_pkg::*; #(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = IO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt, w_cnt_nx;
  logic r_full, r_empty;
  assign w_cnt_nx = r_cnt + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp] <= din;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (push) r_wp <= r_wp + 1'b1;
      if (pop) r_rp <= r_rp + 1'b1;
      r_cnt   <= w_cnt_nx;
      r_full  <= w_cnt_nx == (AW+1)'(DEPTH);
      r_empty <= w_cnt_nx == '0;
    end
  end
  assign head  = r_empty ? '0 : r_mem[r_rp];
  assign count = r_cnt;
  assign full  = r_full;
  assign empty = r_empty;
endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: buffered OUT/IN port peripheral with RX-arrival interrupt
module io_port_ctrl import io_port_pkg::*; #(
  parameter int DATA_W  = IO_DATA_W,
  parameter int DEPTH   = IO_DEPTH,
  parameter int INT_LEN = IO_INT_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      cpu_out_data,
  input  logic                   cpu_out_we,
  output logic [DATA_W-1:0]      cpu_in_data,
  input  logic                   cpu_in_re,
  output logic                   cpu_int,
  input  logic [DATA_W-1:0]      ext_rx_data,
  input  logic                   ext_rx_valid,
  output logic                   ext_rx_ready,
  output logic [DATA_W-1:0]      ext_tx_data,
  output logic                   ext_tx_valid,
  input  logic                   ext_tx_ready,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic                   tx_ovf,
  output logic                   rx_udf
);
  localparam int PW = $clog2(INT_LEN + 1);
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic r_tx_ovf, r_rx_udf, r_int;
  logic [PW-1:0] r_pcnt;
  int_state_t r_state;
  assign w_tx_push = cpu_out_we & ~w_tx_full;
  assign w_tx_pop  = ~w_tx_empty & ext_tx_ready;
  assign w_rx_push = ext_rx_valid & ~w_rx_full;
  assign w_rx_pop  = cpu_in_re & ~w_rx_empty;
  io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(w_tx_push), .pop(w_tx_pop), .din(cpu_out_data),
    .head(ext_tx_data), .count(tx_count), .full(w_tx_full), .empty(w_tx_empty)
  );
  io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(w_rx_push), .pop(w_rx_pop), .din(ext_rx_data),
    .head(cpu_in_data), .count(rx_count), .full(w_rx_full), .empty(w_rx_empty)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      r_tx_ovf <= r_tx_ovf | (cpu_out_we & w_tx_full);
      r_rx_udf <= r_rx_udf | (cpu_in_re & w_rx_empty);
    end
  end
  // one pulse per empty-to-non-empty burst; re-arms only once RX is seen empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pcnt  <= '0;
      r_int   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_rx_empty && w_rx_push) begin
          r_state <= PULSE;
          r_pcnt  <= PW'(INT_LEN - 1);
          r_int   <= 1'b1;
        end
        PULSE: if (r_pcnt == '0) begin
          r_state <= WAIT_EMPTY;
          r_int   <= 1'b0;
        end else r_pcnt <= r_pcnt - 1'b1;
        WAIT_EMPTY: if (w_rx_empty) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign ext_tx_valid = ~w_tx_empty;
  assign ext_rx_ready = ~w_rx_full;
  assign cpu_int      = r_int;
  assign tx_ovf       = r_tx_ovf;
  assign rx_udf       = r_rx_udf;
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed and randomized checks of io_port_ctrl against a queue-based model
module tb_io_port_ctrl;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int INT_LEN = 2;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] cpu_out_data, cpu_in_data, ext_rx_data, ext_tx_data;
  logic cpu_out_we, cpu_in_re, cpu_int, ext_rx_valid, ext_rx_ready, ext_tx_valid, ext_tx_ready;
  logic [CW-1:0] rx_count, tx_count;
  logic tx_ovf, rx_udf;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  bit m_ovf, m_udf, armed;
  int hi_left;
  io_port_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .INT_LEN(INT_LEN)) dut (
    .clk(clk), .rst(rst), .cpu_out_data(cpu_out_data), .cpu_out_we(cpu_out_we),
    .cpu_in_data(cpu_in_data), .cpu_in_re(cpu_in_re), .cpu_int(cpu_int),
    .ext_rx_data(ext_rx_data), .ext_rx_valid(ext_rx_valid), .ext_rx_ready(ext_rx_ready),
    .ext_tx_data(ext_tx_data), .ext_tx_valid(ext_tx_valid), .ext_tx_ready(ext_tx_ready),
    .rx_count(rx_count), .tx_count(tx_count), .tx_ovf(tx_ovf), .rx_udf(rx_udf)
  );
  always #5 clk = ~clk;
  task automatic m_reset();
    tx_q.delete();
    rx_q.delete();
    m_ovf = 0;
    m_udf = 0;
    armed = 1;
    hi_left = 0;
  endtask
  task automatic m_edge();
    bit txpop, txpush, rxpush, rxpop, was_empty;
    txpop = tx_q.size() > 0 && ext_tx_ready;
    txpush = cpu_out_we && tx_q.size() < DEPTH;
    if (cpu_out_we && tx_q.size() == DEPTH) m_ovf = 1;
    rxpush = ext_rx_valid && rx_q.size() < DEPTH;
    rxpop = cpu_in_re && rx_q.size() > 0;
    if (cpu_in_re && rx_q.size() == 0) m_udf = 1;
    was_empty = rx_q.size() == 0;
    if (hi_left > 0) hi_left--;
    else if (!armed && was_empty) armed = 1;
    else if (armed && was_empty && rxpush) begin
      armed = 0;
      hi_left = INT_LEN;
    end
    if (txpop) void'(tx_q.pop_front());
    if (txpush) tx_q.push_back(cpu_out_data);
    if (rxpop) void'(rx_q.pop_front());
    if (rxpush) rx_q.push_back(ext_rx_data);
  endtask
  task automatic tick();
    m_edge();
    @(negedge clk);
  endtask
  task automatic test_reset();
    if ({rx_count, tx_count, cpu_int, ext_rx_ready, ext_tx_valid, tx_ovf, rx_udf, cpu_in_data, ext_tx_data} !==
        {CW'(0), CW'(0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      errors++; $display("FAIL reset_initial got rx=%0d tx=%0d int=%b rdy=%b vld=%b", rx_count, tx_count, cpu_int, ext_rx_ready, ext_tx_valid);
    end
    checks++;
    ext_tx_ready = 0;
    for (int i = 0; i < 2; i++) begin
      cpu_out_we = 1; cpu_out_data = 8'h60 + 8'(i);
      ext_rx_valid = 1; ext_rx_data = 8'h70 + 8'(i);
      tick();
    end
    cpu_out_we = 0; ext_rx_valid = 0;
    if ({tx_count, rx_count} !== {CW'(tx_q.size()), CW'(rx_q.size())} || tx_count !== CW'(2)) begin
      errors++; $display("FAIL reset_prefill got tx=%0d rx=%0d want 2 2", tx_count, rx_count);
    end
    checks++;
    #2 rst = 0;
    #1;
    if ({rx_count, tx_count, ext_tx_valid} !== {CW'(0), CW'(0), 1'b0}) begin
      errors++; $display("FAIL reset_async got rx=%0d tx=%0d vld=%b want 0 0 0", rx_count, tx_count, ext_tx_valid);
    end
    checks++;
    m_reset();
    repeat (3) @(negedge clk);
    if ({rx_count, tx_count, cpu_int, ext_rx_ready, ext_tx_valid, tx_ovf, rx_udf, cpu_in_data, ext_tx_data} !==
        {CW'(0), CW'(0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      errors++; $display("FAIL reset_held got rx=%0d tx=%0d int=%b rdy=%b vld=%b ovf=%b udf=%b", rx_count, tx_count, cpu_int, ext_rx_ready, ext_tx_valid, tx_ovf, rx_udf);
    end
    checks++;
    rst = 1;
    tick();
  endtask
  task automatic test_tx_order_full();
    logic [DW-1:0] vals[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    ext_tx_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cpu_out_we = 1; cpu_out_data = vals[i];
      tick();
    end
    cpu_out_we = 0;
    if ({tx_count, tx_ovf, ext_tx_valid} !== {CW'(4), 1'b1, 1'b1}) begin
      errors++; $display("FAIL tx_full got count=%0d ovf=%b want 4 1", tx_count, tx_ovf);
    end
    checks++;
    ext_tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if ({ext_tx_valid, ext_tx_data} !== {1'b1, vals[i]}) begin
        errors++; $display("FAIL tx_order[%0d] got vld=%b data=%h want 1 %h", i, ext_tx_valid, ext_tx_data, vals[i]);
      end
      checks++;
      tick();
    end
    if ({ext_tx_valid, tx_count, ext_tx_data} !== {1'b0, CW'(0), 8'h00}) begin
      errors++; $display("FAIL tx_drained got vld=%b count=%0d data=%h want 0 0 00", ext_tx_valid, tx_count, ext_tx_data);
    end
    checks++;
    ext_tx_ready = 0;
  endtask
  task automatic test_rx_int();
    logic [4:0] seen;
    ext_rx_valid = 1; ext_rx_data = 8'hA5;
    if (cpu_int !== 1'b0) begin
      errors++; $display("FAIL rx_int_pre got %b want 0", cpu_int);
    end
    checks++;
    tick();
    ext_rx_data = 8'h3C;
    for (int k = 0; k < 5; k++) begin
      seen[k] = cpu_int;
      tick();
      ext_rx_valid = 0;
    end
    if (seen !== 5'b00011) begin
      errors++; $display("FAIL rx_int_pulse got %b want 00011", seen);
    end
    checks++;
    if ({rx_count, cpu_in_data} !== {CW'(2), 8'hA5}) begin
      errors++; $display("FAIL rx_head got count=%0d data=%h want 2 a5", rx_count, cpu_in_data);
    end
    checks++;
    cpu_in_re = 1;
    tick();
    if (cpu_in_data !== 8'h3C) begin
      errors++; $display("FAIL rx_pop1 got %h want 3c", cpu_in_data);
    end
    checks++;
    tick();
    cpu_in_re = 0;
    if ({rx_count, cpu_in_data, rx_udf} !== {CW'(0), 8'h00, 1'b0}) begin
      errors++; $display("FAIL rx_pop2 got count=%0d data=%h udf=%b want 0 00 0", rx_count, cpu_in_data, rx_udf);
    end
    checks++;
    tick();
  endtask
  task automatic test_rearm();
    logic [4:0] seen;
    ext_rx_valid = 1; ext_rx_data = 8'h7E;
    tick();
    ext_rx_valid = 0;
    for (int k = 0; k < 5; k++) begin
      seen[k] = cpu_int;
      tick();
    end
    if (seen !== 5'b00011) begin
      errors++; $display("FAIL rearm_pulse got %b want 00011", seen);
    end
    checks++;
    ext_rx_valid = 1; ext_rx_data = 8'h01;
    tick();
    ext_rx_valid = 0;
    for (int k = 0; k < 5; k++) begin
      seen[k] = cpu_int;
      tick();
    end
    if (seen !== 5'b00000 || rx_count !== CW'(2)) begin
      errors++; $display("FAIL rearm_nopulse got int=%b count=%0d want 00000 2", seen, rx_count);
    end
    checks++;
    cpu_in_re = 1;
    tick();
    tick();
    cpu_in_re = 0;
    tick();
  endtask
  task automatic test_underflow();
    cpu_in_re = 1;
    if (cpu_in_data !== 8'h00) begin
      errors++; $display("FAIL udf_data got %h want 00", cpu_in_data);
    end
    checks++;
    tick();
    cpu_in_re = 0;
    if ({rx_udf, rx_count} !== {1'b1, CW'(0)}) begin
      errors++; $display("FAIL udf_flag got udf=%b count=%0d want 1 0", rx_udf, rx_count);
    end
    checks++;
    ext_rx_valid = 1; ext_rx_data = 8'h9A;
    tick();
    ext_rx_valid = 0;
    if ({cpu_in_data, rx_count} !== {8'h9A, CW'(1)}) begin
      errors++; $display("FAIL udf_nomove got data=%h count=%0d want 9a 1", cpu_in_data, rx_count);
    end
    checks++;
    cpu_in_re = 1;
    tick();
    cpu_in_re = 0;
    tick();
  endtask
  task automatic test_wrap();
    logic [DW-1:0] exp[$];
    for (int i = 0; i < 3; i++) begin
      ext_rx_valid = 1; ext_rx_data = 8'hF1 + 8'(i);
      exp.push_back(ext_rx_data);
      tick();
    end
    cpu_in_re = 1;
    for (int i = 1; i <= 6; i++) begin
      ext_rx_data = 8'(i);
      exp.push_back(ext_rx_data);
      if ({rx_count, cpu_in_data} !== {CW'(3), exp[0]}) begin
        errors++; $display("FAIL wrap[%0d] got count=%0d data=%h want 3 %h", i, rx_count, cpu_in_data, exp[0]);
      end
      checks++;
      void'(exp.pop_front());
      tick();
    end
    cpu_in_re = 0;
    ext_rx_data = 8'h07;
    exp.push_back(ext_rx_data);
    tick();
    if ({ext_rx_ready, rx_count} !== {1'b0, CW'(4)}) begin
      errors++; $display("FAIL rx_full got ready=%b count=%0d want 0 4", ext_rx_ready, rx_count);
    end
    checks++;
    ext_rx_data = 8'hEE;
    tick();
    tick();
    ext_rx_valid = 0;
    cpu_in_re = 1;
    for (int i = 0; i < 4; i++) begin
      if ({rx_count, cpu_in_data} !== {CW'(4 - i), exp[0]}) begin
        errors++; $display("FAIL full_drain[%0d] got count=%0d data=%h want %0d %h", i, rx_count, cpu_in_data, 4 - i, exp[0]);
      end
      checks++;
      void'(exp.pop_front());
      tick();
    end
    cpu_in_re = 0;
    tick();
  endtask
  task automatic test_random();
    logic [2*DW+2*CW+5-1:0] got, want;
    for (int n = 0; n < 600; n++) begin
      cpu_out_we   = $urandom_range(0, 1) == 1;
      cpu_out_data = 8'($urandom);
      ext_tx_ready = n < 300 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      ext_rx_valid = n < 300 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 4) == 0;
      ext_rx_data  = 8'($urandom);
      cpu_in_re    = n < 300 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 1) == 1;
      tick();
      got  = {ext_tx_valid, ext_tx_data, ext_rx_ready, cpu_in_data, cpu_int, tx_count, rx_count, tx_ovf, rx_udf};
      want = {tx_q.size() > 0, tx_q.size() > 0 ? tx_q[0] : 8'h00, rx_q.size() < DEPTH,
              rx_q.size() > 0 ? rx_q[0] : 8'h00, hi_left > 0, CW'(tx_q.size()), CW'(rx_q.size()), m_ovf, m_udf};
      if (got !== want) begin
        errors++; $display("FAIL random[%0d] got %h want %h", n, got, want);
      end
      checks++;
    end
    cpu_out_we = 0; ext_rx_valid = 0; cpu_in_re = 0; ext_tx_ready = 0;
  endtask
  initial begin
    rst = 0;
    cpu_out_data = 0; cpu_out_we = 0; cpu_in_re = 0;
    ext_rx_data = 0; ext_rx_valid = 0; ext_tx_ready = 0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1;
    test_reset();
    test_tx_order_full();
    test_rx_int();
    test_rearm();
    test_underflow();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
